h264residual: RTL and testbench

- Encoder-side counterpart of the reconstruction stage.
- Takes original pixels and intra/inter prediction, both as 4x8-bit words, and computes signed residuals (cur - pred) for the forward transform.
- Forwards each consumed prediction word on a base stream (BSTROBEO/BCHROMAO/BASEO) that feeds the reconstruction block's base input.
- Buffers prediction blocks in a small tagged FIFO so prediction may run ahead of the original-pixel stream.

---
 rtl/h264residual_pkg.sv | 39 +++
 rtl/h264residual_if.sv | 26 ++
 rtl/h264residual_pred_fifo.sv | 82 ++++++++
 rtl/h264residual.sv | 68 ++++++
 tb/tb_h264residual.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/h264residual_pkg.sv
// Shared widths, word types and lane helpers for the encoder residual path.
package h264_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned RES_W     = 9;
  localparam int unsigned LANES     = 4;
  localparam int unsigned BLK_WORDS = 4;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [RES_W-1:0]  res_t;
  typedef logic [LANES*PIX_W-1:0]   pix_word_t;
  typedef logic [LANES*RES_W-1:0]   res_word_t;

  function automatic pix_t pix_lane(pix_word_t w, int unsigned k);
    return w[k*PIX_W +: PIX_W];
  endfunction

  function automatic res_word_t res_pack(res_word_t w, int unsigned k, res_t r);
    res_word_t o;
    o = w;
    o[k*RES_W +: RES_W] = r;
    return o;
  endfunction

  // Zero-extend both operands so the 9-bit difference covers -255..+255 exactly.
  function automatic res_t residual(pix_t cur, pix_t pred);
    return $signed({1'b0, cur} - {1'b0, pred});
  endfunction

  function automatic res_word_t residual_word(pix_word_t cur, pix_word_t pred);
    res_word_t o;
    o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      o = res_pack(o, k, residual(pix_lane(cur, k), pix_lane(pred, k)));
    end
    return o;
  endfunction

endpackage

// File: rtl/h264residual_if.sv
// Prediction, original-pixel, residual and base streams of the residual stage.
interface h264residual_if;
  logic        PSTROBEI;
  logic        PCHROMAI;
  logic [31:0] PREDI;
  logic        READYO;
  logic        STROBEI;
  logic [31:0] CURI;
  logic        STROBEO;
  logic        CHROMAO;
  logic [35:0] DATAO;
  logic        BSTROBEO;
  logic        BCHROMAO;
  logic [31:0] BASEO;
  logic        ERRO;

  modport master (
    output PSTROBEI, PCHROMAI, PREDI, STROBEI, CURI,
    input  READYO, STROBEO, CHROMAO, DATAO, BSTROBEO, BCHROMAO, BASEO, ERRO
  );

  modport slave (
    input  PSTROBEI, PCHROMAI, PREDI, STROBEI, CURI,
    output READYO, STROBEO, CHROMAO, DATAO, BSTROBEO, BCHROMAO, BASEO, ERRO
  );
endinterface

// File: rtl/h264residual_pred_fifo.sv
// Prediction word FIFO with one chroma tag per 4-word block and burst alignment check.
module h264pred_fifo
  import h264_pkg::*;
#(
  parameter int unsigned FIFO_BLOCKS = 2,
  localparam int unsigned DEPTH = FIFO_BLOCKS * BLK_WORDS,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             push_tag,
  input  pix_word_t        push_data,
  input  logic             pop,
  output pix_word_t        pop_data,
  output logic             pop_tag,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             align_err
);

  localparam int unsigned BLK_W = (FIFO_BLOCKS > 1) ? $clog2(FIFO_BLOCKS) : 1;

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;
  logic             prev_push, prev_pop;
  pix_word_t        mem [DEPTH];
  logic             tags [2**BLK_W];

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full      = (cnt == CNT_W'(DEPTH));
    empty     = (cnt == '0);
    do_push   = push && !full && !flush;
    do_pop    = pop && !empty && !flush;
    count     = cnt;
    pop_data  = mem[rptr];
    pop_tag   = tags[BLK_W'(rptr >> 2)];
    // A burst must end on a block boundary; flagged on the strobe's falling cycle.
    align_err = !flush &&
                ((prev_push && !push && (wptr[1:0] != 2'd0)) ||
                 (prev_pop  && !pop  && (rptr[1:0] != 2'd0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      prev_push <= 1'b0;
      prev_pop  <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      prev_push <= 1'b0;
      prev_pop  <= 1'b0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      prev_push <= push;
      prev_pop  <= pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
      if (wptr[1:0] == 2'd0) tags[BLK_W'(wptr >> 2)] <= push_tag;
    end
  end

endmodule

// File: rtl/h264residual.sv
// Encoder residual stage: cur - pred per lane, with prediction forwarded as the base stream.
module h264residual
  import h264_pkg::*;
#(
  parameter int unsigned FIFO_BLOCKS = 2
) (
  input  logic    CLK2,
  input  logic    RSTN,
  input  logic    NEWSLICE,
  h264residual_if.slave bus
);

  localparam int unsigned DEPTH = FIFO_BLOCKS * BLK_WORDS;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pix_word_t        pop_data;
  logic             pop_tag;
  logic [CNT_W-1:0] count;
  logic             full, empty, align_err;
  logic             pop_ok, overflow, underflow;

  h264pred_fifo #(.FIFO_BLOCKS(FIFO_BLOCKS)) u_fifo (
    .clk       (CLK2),
    .rst_n     (RSTN),
    .flush     (NEWSLICE),
    .push      (bus.PSTROBEI),
    .push_tag  (bus.PCHROMAI),
    .push_data (bus.PREDI),
    .pop       (bus.STROBEI),
    .pop_data  (pop_data),
    .pop_tag   (pop_tag),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .align_err (align_err)
  );

  always_comb begin
    pop_ok     = bus.STROBEI && !empty && !NEWSLICE;
    overflow   = bus.PSTROBEI && full;
    underflow  = bus.STROBEI && empty;
    bus.READYO = (count <= CNT_W'(DEPTH - BLK_WORDS));
  end

  always_ff @(posedge CLK2 or negedge RSTN) begin
    if (!RSTN) begin
      bus.STROBEO  <= 1'b0;
      bus.CHROMAO  <= 1'b0;
      bus.DATAO    <= '0;
      bus.BSTROBEO <= 1'b0;
      bus.BCHROMAO <= 1'b0;
      bus.BASEO    <= '0;
      bus.ERRO     <= 1'b0;
    end else begin
      bus.STROBEO  <= pop_ok;
      bus.BSTROBEO <= pop_ok;
      if (pop_ok) begin
        bus.DATAO    <= residual_word(bus.CURI, pop_data);
        bus.BASEO    <= pop_data;
        bus.CHROMAO  <= pop_tag;
        bus.BCHROMAO <= pop_tag;
      end
      if (NEWSLICE)                                bus.ERRO <= 1'b0;
      else if (overflow || underflow || align_err) bus.ERRO <= 1'b1;
    end
  end

endmodule

// File: tb/tb_h264residual.sv
// Directed bench for h264residual with hand-computed residual, tag and error expectations.
module tb_h264residual;

  logic CLK2 = 1'b0;
  logic RSTN;
  logic NEWSLICE;
  int   n_cmp = 0;
  int   n_err = 0;

  h264residual_if bus ();

  h264residual #(.FIFO_BLOCKS(2)) dut (
    .CLK2     (CLK2),
    .RSTN     (RSTN),
    .NEWSLICE (NEWSLICE),
    .bus      (bus.slave)
  );

  always #5 CLK2 = ~CLK2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK2);
    #1;
  endtask

  task automatic push_block(input logic [31:0] pred, input logic chroma);
    bus.PREDI    = pred;
    bus.PCHROMAI = chroma;
    bus.PSTROBEI = 1'b1;
    repeat (4) step();
    bus.PSTROBEI = 1'b0;
    bus.PCHROMAI = 1'b0;
  endtask

  task automatic pop_block(input string tag, input logic [31:0] cur, input logic [35:0] exp_data,
                           input logic [31:0] exp_base, input logic exp_chroma);
    bus.CURI    = cur;
    bus.STROBEI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check({tag, "_strobe"},  bus.STROBEO,  1);
      check({tag, "_bstrobe"}, bus.BSTROBEO, 1);
      check({tag, "_data"},    bus.DATAO,    exp_data);
      check({tag, "_base"},    bus.BASEO,    exp_base);
      check({tag, "_chroma"},  bus.CHROMAO,  exp_chroma);
      check({tag, "_bchroma"}, bus.BCHROMAO, exp_chroma);
    end
    bus.STROBEI = 1'b0;
  endtask

  initial begin
    RSTN         = 1'b0;
    NEWSLICE     = 1'b0;
    bus.PSTROBEI = 1'b0;
    bus.PCHROMAI = 1'b0;
    bus.PREDI    = '0;
    bus.STROBEI  = 1'b0;
    bus.CURI     = '0;
    repeat (2) step();

    check("rst_strobe",  bus.STROBEO,  0);
    check("rst_bstrobe", bus.BSTROBEO, 0);
    check("rst_data",    bus.DATAO,    0);
    check("rst_base",    bus.BASEO,    0);
    check("rst_chroma",  bus.CHROMAO,  0);
    check("rst_err",     bus.ERRO,     0);
    check("rst_ready",   bus.READYO,   1);

    RSTN = 1'b1;
    step();

    // Luma block: lanes +127, -128, +1, -1 from lane0 up.
    push_block(32'h80808080, 1'b0);
    step();
    check("t1_idle_strobe", bus.STROBEO, 0);
    pop_block("t1", 32'h7F8100FF, {9'h1FF, 9'h001, 9'h180, 9'h07F}, 32'h80808080, 1'b0);
    step();
    check("t1_end_strobe", bus.STROBEO, 0);
    check("t1_hold_data",  bus.DATAO, {9'h1FF, 9'h001, 9'h180, 9'h07F});
    check("t1_err",        bus.ERRO, 0);

    // Extremes: +255 / -255 alternating.
    push_block(32'hFF00FF00, 1'b0);
    pop_block("t2", 32'h00FF00FF, {9'h101, 9'h0FF, 9'h101, 9'h0FF}, 32'hFF00FF00, 1'b0);
    step();
    check("t2_err", bus.ERRO, 0);

    // Fill with a luma then a chroma block, overflow, then drain.
    bus.PSTROBEI = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.PCHROMAI = (i >= 4);
      bus.PREDI    = 32'hA0000000 | i;
      step();
      if (i == 3) check("t3_ready_half", bus.READYO, 1);
    end
    check("t3_ready_full", bus.READYO, 0);
    check("t3_err_pre",    bus.ERRO, 0);
    bus.PREDI = 32'hDEADBEEF;
    step();
    check("t3_overflow_err", bus.ERRO, 1);
    bus.PSTROBEI = 1'b0;
    bus.PCHROMAI = 1'b0;
    bus.CURI     = '0;
    bus.STROBEI  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_drain_strobe", bus.STROBEO, 1);
      check("t3_drain_chroma", bus.CHROMAO, (i >= 4));
      check("t3_drain_base",   bus.BASEO, 32'hA0000000 | i);
    end
    bus.STROBEI = 1'b0;
    step();
    check("t3_ready_empty", bus.READYO, 1);
    NEWSLICE = 1'b1;
    step();
    NEWSLICE = 1'b0;
    check("t3_flush_err", bus.ERRO, 0);

    // Underflow then slice flush.
    bus.STROBEI = 1'b1;
    step();
    check("t4_uf_strobe", bus.STROBEO, 0);
    check("t4_uf_err",    bus.ERRO, 1);
    bus.STROBEI = 1'b0;
    NEWSLICE    = 1'b1;
    step();
    NEWSLICE = 1'b0;
    check("t4_flush_err",   bus.ERRO, 0);
    check("t4_flush_ready", bus.READYO, 1);

    // Flush in the middle of a pop burst, then a clean block.
    push_block(32'h10203040, 1'b1);
    bus.CURI    = 32'h10203040;
    bus.STROBEI = 1'b1;
    step();
    step();
    check("t5_mid_strobe", bus.STROBEO, 1);
    check("t5_mid_chroma", bus.CHROMAO, 1);
    NEWSLICE = 1'b1;
    step();
    check("t5_flush_strobe",  bus.STROBEO, 0);
    check("t5_flush_bstrobe", bus.BSTROBEO, 0);
    check("t5_flush_ready",   bus.READYO, 1);
    NEWSLICE    = 1'b0;
    bus.STROBEI = 1'b0;
    step();
    check("t5_post_err", bus.ERRO, 0);
    push_block(32'h01020304, 1'b0);
    pop_block("t5", 32'h05050505, {9'd4, 9'd3, 9'd2, 9'd1}, 32'h01020304, 1'b0);
    step();
    check("t5_end_err", bus.ERRO, 0);

    // Short prediction burst, then an asynchronous reset mid-cycle.
    bus.PREDI    = 32'h80808080;
    bus.PSTROBEI = 1'b1;
    repeat (3) step();
    bus.PSTROBEI = 1'b0;
    bus.CURI     = 32'h7F8100FF;
    bus.STROBEI  = 1'b1;
    step();
    check("t6_align_err", bus.ERRO, 1);
    check("t6_strobe",    bus.STROBEO, 1);
    check("t6_data",      bus.DATAO, {9'h1FF, 9'h001, 9'h180, 9'h07F});
    bus.STROBEI = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    check("t6_arst_strobe",  bus.STROBEO, 0);
    check("t6_arst_bstrobe", bus.BSTROBEO, 0);
    check("t6_arst_data",    bus.DATAO, 0);
    check("t6_arst_base",    bus.BASEO, 0);
    check("t6_arst_err",     bus.ERRO, 0);
    check("t6_arst_ready",   bus.READYO, 1);
    step();
    RSTN = 1'b1;
    step();
    check("t6_post_err", bus.ERRO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
